// File: rtl/regfile_exec_pkg.sv
// Shared types and default widths for the regfile execute sequencer.
// Op/shift encodings match the command-port bit patterns.
package regfile_exec_pkg;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 3;

  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_CMP = 2'b01, OP_AND = 2'b10, OP_MVN = 2'b11} op_e;
  typedef enum logic [1:0] {SH_NONE = 2'b00, SH_LSL = 2'b01, SH_LSR = 2'b10, SH_ASR = 2'b11} shift_e;
  typedef enum logic [2:0] {S_IDLE, S_READ_A, S_READ_B, S_EXEC, S_WB} state_e;
endpackage

// File: rtl/regfile.sv
// Eight-entry register file: one synchronous write port, one combinational read port.
// Write captured on the rising edge when i_write is high; no reset on storage.
module regfile #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          i_clk,
  input  logic          i_write,
  input  logic [AW-1:0] i_writenum,
  input  logic [DW-1:0] i_data_in,
  input  logic [AW-1:0] i_readnum,
  output logic [DW-1:0] o_data_out
);
  logic [DW-1:0] r_regs [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_write) r_regs[i_writenum] <= i_data_in;
  end

  assign o_data_out = r_regs[i_readnum];
endmodule

// File: rtl/shift_alu.sv
// Combinational barrel-of-one shifter on B feeding a 4-op ALU with {N,V,Z} flags.
// Latency: none (pure combinational); no handshake.
module shift_alu
  import regfile_exec_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  op_e           i_op,
  input  shift_e        i_shift,
  output logic [DW-1:0] o_result,
  output logic          o_n,
  output logic          o_v,
  output logic          o_z
);
  logic [DW-1:0] w_sb;
  logic [DW-1:0] w_res;
  logic          w_v;

  always_comb begin
    w_sb = i_b;
    case (i_shift)
      SH_LSL:  w_sb = {i_b[DW-2:0], 1'b0};
      SH_LSR:  w_sb = {1'b0, i_b[DW-1:1]};
      SH_ASR:  w_sb = {i_b[DW-1], i_b[DW-1:1]};
      default: w_sb = i_b;
    endcase
  end

  always_comb begin
    w_res = '0;
    w_v   = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_res = i_a + w_sb;
        w_v   = (i_a[DW-1] == w_sb[DW-1]) && (w_res[DW-1] != i_a[DW-1]);
      end
      // CMP is a subtract whose result is kept only for the flags
      OP_CMP: begin
        w_res = i_a - w_sb;
        w_v   = (i_a[DW-1] != w_sb[DW-1]) && (w_res[DW-1] != i_a[DW-1]);
      end
      OP_AND:  w_res = i_a & w_sb;
      default: w_res = ~w_sb;
    endcase
  end

  assign o_result = w_res;
  assign o_n      = w_res[DW-1];
  assign o_v      = w_v;
  assign o_z      = (w_res == '0);
endmodule

// File: rtl/regfile_exec_seq.sv
// Multi-cycle execute sequencer: read Rn, read Rm, execute, write back Rd; one command at a time.
// Start accepted at edge k -> regfile written at edge k+4 -> done pulses the following cycle.
module regfile_exec_seq
  import regfile_exec_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [1:0]    i_op,
  input  logic [1:0]    i_shift,
  input  logic [AW-1:0] i_rd,
  input  logic [AW-1:0] i_rn,
  input  logic [AW-1:0] i_rm,
  output logic          o_busy,
  output logic          o_done,
  output logic [2:0]    o_status,
  output logic [AW-1:0] o_rf_readnum,
  input  logic [DW-1:0] i_rf_data_out,
  output logic [AW-1:0] o_rf_writenum,
  output logic          o_rf_write,
  output logic [DW-1:0] o_rf_data_in
);
  state_e        r_state, w_next;
  op_e           r_op;
  shift_e        r_shift;
  logic [AW-1:0] r_rd, r_rn, r_rm;
  logic [DW-1:0] r_a, r_b, r_c;
  logic [2:0]    r_status;
  logic          r_done;

  logic [DW-1:0] w_res;
  logic          w_n, w_v, w_z;

  shift_alu #(.DW(DW)) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .i_shift  (r_shift),
    .o_result (w_res),
    .o_n      (w_n),
    .o_v      (w_v),
    .o_z      (w_z)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_busy       = 1'b1;
    o_rf_write   = 1'b0;
    o_rf_readnum = r_rn;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = S_READ_A;
      end
      S_READ_A: w_next = S_READ_B;
      S_READ_B: begin
        o_rf_readnum = r_rm;
        w_next       = S_EXEC;
      end
      S_EXEC: w_next = S_WB;
      S_WB: begin
        o_rf_write = (r_op != OP_CMP);
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_op     <= OP_ADD;
      r_shift  <= SH_NONE;
      r_rd     <= '0;
      r_rn     <= '0;
      r_rm     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_status <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_WB);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op    <= op_e'(i_op);
            r_shift <= shift_e'(i_shift);
            r_rd    <= i_rd;
            r_rn    <= i_rn;
            r_rm    <= i_rm;
          end
        end
        S_READ_A: r_a <= i_rf_data_out;
        S_READ_B: r_b <= i_rf_data_out;
        S_EXEC: begin
          r_c      <= w_res;
          r_status <= {w_n, w_v, w_z};
        end
        default: ;
      endcase
    end
  end

  assign o_done        = r_done;
  assign o_status      = r_status;
  assign o_rf_writenum = r_rd;
  assign o_rf_data_in  = r_c;
endmodule

// File: tb/tb_regfile_exec_seq.sv
// Directed bench: sequencer plus regfile, table of commands with hand-computed results,
// followed by back-to-back/ignored-start and mid-command reset sequences.
module tb_regfile_exec_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op, sh;
  logic [2:0]  rd, rn, rm;
  logic        busy, done;
  logic [2:0]  status;
  logic [2:0]  dut_readnum, dut_writenum;
  logic        dut_write;
  logic [15:0] dut_data_in, rf_data_out;

  logic        ld_en;
  logic [2:0]  ld_num;
  logic [15:0] ld_dat;
  logic        rf_write;
  logic [2:0]  rf_writenum;
  logic [15:0] rf_data_in;

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  logic [15:0] m_regs [8];

  always #5 clk = ~clk;

  regfile_exec_seq #(.DW(16), .AW(3)) u_dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_op          (op),
    .i_shift       (sh),
    .i_rd          (rd),
    .i_rn          (rn),
    .i_rm          (rm),
    .o_busy        (busy),
    .o_done        (done),
    .o_status      (status),
    .o_rf_readnum  (dut_readnum),
    .i_rf_data_out (rf_data_out),
    .o_rf_writenum (dut_writenum),
    .o_rf_write    (dut_write),
    .o_rf_data_in  (dut_data_in)
  );

  assign rf_write    = ld_en | dut_write;
  assign rf_writenum = ld_en ? ld_num : dut_writenum;
  assign rf_data_in  = ld_en ? ld_dat : dut_data_in;

  regfile #(.DW(16), .AW(3)) u_rf (
    .i_clk      (clk),
    .i_write    (rf_write),
    .i_writenum (rf_writenum),
    .i_data_in  (rf_data_in),
    .i_readnum  (dut_readnum),
    .o_data_out (rf_data_out)
  );

  always @(negedge clk) if (dut_write) wr_cnt++;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sh;
    logic [2:0]  rd, rn, rm;
    logic [15:0] exp_c;
    logic [2:0]  exp_st;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string name);
    int bad = 0;
    for (int i = 0; i < 8; i++) if (u_rf.r_regs[i] !== m_regs[i]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic load(input logic [2:0] num, input logic [15:0] val);
    @(negedge clk);
    ld_en = 1'b1; ld_num = num; ld_dat = val;
    @(negedge clk);
    ld_en = 1'b0;
    m_regs[num] = val;
  endtask

  // Drives the command and returns just after the accepting edge, with inputs scrambled.
  task automatic issue(input logic [1:0] o, input logic [1:0] s,
                       input logic [2:0] d, input logic [2:0] n, input logic [2:0] m);
    @(negedge clk);
    wr_cnt = 0;
    start = 1'b1; op = o; sh = s; rd = d; rn = n; rm = m;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; sh = ~s; rd = ~d; rn = ~n; rm = ~m;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
    end
  endtask

  initial begin
    int lat, lat2;
    vecs[0] = '{2'b00, 2'b00, 3'd2, 3'd0, 3'd1, 16'h0012, 3'b000};
    vecs[1] = '{2'b11, 2'b01, 3'd3, 3'd0, 3'd3, 16'hF05F, 3'b100};
    vecs[2] = '{2'b00, 2'b00, 3'd6, 3'd4, 3'd5, 16'h8000, 3'b110};
    vecs[3] = '{2'b01, 2'b00, 3'd7, 3'd4, 3'd4, 16'h0000, 3'b001};
    vecs[4] = '{2'b10, 2'b11, 3'd2, 3'd3, 3'd0, 16'h0001, 3'b000};
    vecs[5] = '{2'b00, 2'b10, 3'd0, 3'd1, 3'd6, 16'h400F, 3'b000};
    vecs[6] = '{2'b01, 2'b00, 3'd5, 3'd1, 3'd0, 16'hC000, 3'b100};
    vecs[7] = '{2'b11, 2'b11, 3'd4, 3'd0, 3'd6, 16'h3FFF, 3'b000};
    vecs[8] = '{2'b01, 2'b00, 3'd1, 3'd6, 3'd5, 16'h7FFF, 3'b010};
    vecs[9] = '{2'b00, 2'b01, 3'd1, 3'd1, 3'd1, 16'h002D, 3'b000};

    rst = 1'b1; start = 1'b0; op = '0; sh = '0; rd = '0; rn = '0; rm = '0;
    ld_en = 1'b0; ld_num = '0; ld_dat = '0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_status", status, 0);
    chk("reset_rf_write", dut_write, 0);
    chk("reset_readnum", dut_readnum, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    load(0, 16'd3);    load(1, 16'd15);   load(2, 16'h0000); load(3, 16'd2000);
    load(4, 16'h7FFF); load(5, 16'h0001); load(6, 16'h0000); load(7, 16'h1234);

    for (int v = 0; v < 10; v++) begin
      issue(vecs[v].op, vecs[v].sh, vecs[v].rd, vecs[v].rn, vecs[v].rm);
      chk($sformatf("v%0d_busy", v), busy, 1);
      wait_done(lat);
      chk($sformatf("v%0d_latency", v), lat, 4);
      chk($sformatf("v%0d_status", v), status, vecs[v].exp_st);
      chk($sformatf("v%0d_c", v), dut_data_in, vecs[v].exp_c);
      chk($sformatf("v%0d_writes", v), wr_cnt, (vecs[v].op == 2'b01) ? 0 : 1);
      if (vecs[v].op != 2'b01) m_regs[vecs[v].rd] = vecs[v].exp_c;
      chk_regs($sformatf("v%0d_regs", v));
    end

    // Start pulsed in READ_B must be dropped; second command issued on the done edge.
    issue(2'b00, 2'b00, 3'd2, 3'd5, 3'd5);
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b1; op = 2'b11; sh = 2'b00; rd = 3'd7; rn = 3'd0; rm = 3'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    chk("b2b_first_latency", lat, 2);
    m_regs[2] = 16'h0002;
    start = 1'b1; op = 2'b00; sh = 2'b00; rd = 3'd3; rn = 3'd2; rm = 3'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_done_clears", done, 0);
    chk("b2b_busy", busy, 1);
    wait_done(lat2);
    chk("b2b_done_spacing", lat2 + 1, 5);
    m_regs[3] = 16'h0003;
    chk_regs("b2b_regs");
    @(negedge clk);
    chk("ignored_not_queued", busy, 0);

    issue(2'b01, 2'b00, 3'd0, 3'd5, 3'd5);
    wait_done(lat);
    chk("cmp_z_status", status, 3'b001);

    // Reset while in EXEC aborts the write.
    load(1, 16'd15);
    issue(2'b00, 2'b00, 3'd1, 3'd1, 3'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_rf_write", dut_write, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_write", wr_cnt, 0);
    chk("rst_r1_kept", u_rf.r_regs[1], 16'd15);
    issue(2'b00, 2'b00, 3'd2, 3'd1, 3'd1);
    wait_done(lat);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_status", status, 3'b000);
    m_regs[2] = 16'd30;
    chk_regs("post_rst_regs");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
